uart_tx_ctrl: RTL and testbench

Transmit-side sequencer for the UART_TX datapath. Accepts a byte over a start/ready handshake and drives the serial line through start, data, optional parity and stop bits. Owns the two counters that pace the frame: a bit-time (baud) counter and a bit-index counter with terminal-count detection. Sits between the PicoBlaze output-port decode and the `tx` pin.

---
 rtl/uart_tx_ctrl.sv | 145 ++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: start/ready handshake in, framed serial line out.
// A baud counter paces each bit; a 3-bit index counts data and stop bits.
module uart_tx_ctrl #(
  parameter int unsigned BAUD_DIV   = 5208,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_ready,
  output logic       tx_done
);

  localparam int unsigned CntW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

  localparam logic [CntW-1:0] BaudLast = CntW'(BAUD_DIV - 1);
  localparam logic [2:0]      DataLast = 3'(DATA_BITS - 1);
  localparam logic [2:0]      StopLast = 3'(STOP_BITS - 1);
  localparam logic [7:0]      DataMask = 8'((16'd1 << DATA_BITS) - 16'd1);
  localparam logic            OddSense = (PARITY_ODD != 0);
  localparam logic            HasParity = (PARITY_EN != 0);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] baud_q, baud_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            tick;

  assign tick = (baud_q == BaudLast);

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    done_d   = 1'b0;

    if (state_q != StIdle) begin
      baud_d = tick ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (tx_start) begin
          shift_d  = tx_data & DataMask;
          // Parity is fixed at accept time so later tx_data changes cannot leak in.
          parity_d = (^(tx_data & DataMask)) ^ OddSense;
          baud_d   = '0;
          idx_d    = '0;
          state_d  = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == DataLast) begin
            idx_d   = '0;
            state_d = HasParity ? StParity : StStop;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (tick) begin
          idx_d   = '0;
          state_d = StStop;
        end
      end
      StStop: begin
        if (tick) begin
          if (idx_q == StopLast) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = '0;
        baud_d  = '0;
      end
    endcase
  end

  // Line level is derived from the next state so tx can be a plain flop.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = parity_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
    end
  end

  assign tx       = tx_q;
  assign tx_ready = (state_q == StIdle);
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: four configurations (8N1, 8E1, 8O1, 5N2) at BAUD_DIV=4,
// expected line levels queued per cycle from a frame model and compared as they appear.
module tb_uart_tx_ctrl;

  localparam int Baud = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] st = '0;
  logic [7:0] dt [4];
  logic [3:0] tx_w, rdy_w, done_w;

  int   n_vec = 0;
  int   n_bad = 0;
  logic exp_q [$];

  always #5 clk = ~clk;

  uart_tx_ctrl #(.BAUD_DIV(Baud), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    u_8n1 (.clk(clk), .reset(reset), .tx_start(st[0]), .tx_data(dt[0]),
           .tx(tx_w[0]), .tx_ready(rdy_w[0]), .tx_done(done_w[0]));
  uart_tx_ctrl #(.BAUD_DIV(Baud), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    u_8e1 (.clk(clk), .reset(reset), .tx_start(st[1]), .tx_data(dt[1]),
           .tx(tx_w[1]), .tx_ready(rdy_w[1]), .tx_done(done_w[1]));
  uart_tx_ctrl #(.BAUD_DIV(Baud), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
    u_8o1 (.clk(clk), .reset(reset), .tx_start(st[2]), .tx_data(dt[2]),
           .tx(tx_w[2]), .tx_ready(rdy_w[2]), .tx_done(done_w[2]));
  uart_tx_ctrl #(.BAUD_DIV(Baud), .DATA_BITS(5), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
    u_5n2 (.clk(clk), .reset(reset), .tx_start(st[3]), .tx_data(dt[3]),
           .tx(tx_w[3]), .tx_ready(rdy_w[3]), .tx_done(done_w[3]));

  function automatic int cfg_db(int k);
    return (k == 3) ? 5 : 8;
  endfunction

  function automatic int cfg_pe(int k);
    return (k == 1 || k == 2) ? 1 : 0;
  endfunction

  function automatic int cfg_po(int k);
    return (k == 2) ? 1 : 0;
  endfunction

  function automatic int cfg_sb(int k);
    return (k == 3) ? 2 : 1;
  endfunction

  function automatic int frame_len(int k);
    return Baud * (1 + cfg_db(k) + cfg_pe(k) + cfg_sb(k));
  endfunction

  task automatic push_frame(input int k, input logic [7:0] d);
    logic p;
    p = (cfg_po(k) != 0);
    repeat (Baud) exp_q.push_back(1'b0);
    for (int i = 0; i < cfg_db(k); i++) begin
      p = p ^ d[i];
      repeat (Baud) exp_q.push_back(d[i]);
    end
    if (cfg_pe(k) != 0) repeat (Baud) exp_q.push_back(p);
    repeat (Baud * cfg_sb(k)) exp_q.push_back(1'b1);
  endtask

  // Called at the negedge of the accept cycle N with st[k]=1 already driven.
  task automatic frame_body(input int k, input logic [7:0] d, input bit keep,
                            input logic [7:0] nxt, input bit inject);
    int   f;
    logic e;
    f = frame_len(k);
    push_frame(k, d);
    for (int i = 1; i <= f; i++) begin
      @(negedge clk);
      if (i == 1) begin
        dt[k] = ~d;
        if (!keep) st[k] = 1'b0;
      end
      if (inject && i == f / 2) begin
        st[k] = 1'b1;
        dt[k] = 8'hAA;
      end
      if (inject && i == f / 2 + 1) st[k] = 1'b0;
      e = exp_q.pop_front();
      n_vec++;
      if (tx_w[k] !== e || rdy_w[k] !== 1'b0 || done_w[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL frame u%0d data=%h cyc N+%0d: tx=%b rdy=%b done=%b, required tx=%b rdy=0 done=0",
                 k, d, i, tx_w[k], rdy_w[k], done_w[k], e);
      end
    end
    @(negedge clk);
    n_vec++;
    if (done_w[k] !== 1'b1 || rdy_w[k] !== 1'b1 || tx_w[k] !== 1'b1) begin
      n_bad++;
      $display("FAIL done u%0d data=%h cyc N+%0d: done=%b rdy=%b tx=%b, required 1 1 1",
               k, d, f + 1, done_w[k], rdy_w[k], tx_w[k]);
    end
    if (keep) begin
      dt[k] = nxt;
    end else begin
      @(negedge clk);
      n_vec++;
      if (done_w[k] !== 1'b0 || rdy_w[k] !== 1'b1 || tx_w[k] !== 1'b1) begin
        n_bad++;
        $display("FAIL done_pulse u%0d: done=%b rdy=%b tx=%b, required 0 1 1",
                 k, done_w[k], rdy_w[k], tx_w[k]);
      end
    end
  endtask

  task automatic start_frame(input int k, input logic [7:0] d);
    @(negedge clk);
    n_vec++;
    if (rdy_w[k] !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_before u%0d: rdy=%b, required 1", k, rdy_w[k]);
    end
    st[k] = 1'b1;
    dt[k] = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (tx_w !== 4'hF || rdy_w !== 4'hF || done_w !== 4'h0) begin
      n_bad++;
      $display("FAIL reset_state: tx=%b rdy=%b done=%b, required 1111 1111 0000",
               tx_w, rdy_w, done_w);
    end
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n_vec++;
      if (tx_w !== 4'hF || rdy_w !== 4'hF || done_w !== 4'h0) begin
        n_bad++;
        $display("FAIL reset_idle cyc %0d: tx=%b rdy=%b done=%b, required 1111 1111 0000",
                 i, tx_w, rdy_w, done_w);
      end
    end
  endtask

  task automatic test_basic();
    start_frame(0, 8'h55);
    frame_body(0, 8'h55, 1'b0, 8'h00, 1'b0);
    start_frame(0, 8'hC3);
    frame_body(0, 8'hC3, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_parity();
    start_frame(1, 8'h07);
    frame_body(1, 8'h07, 1'b0, 8'h00, 1'b0);
    start_frame(1, 8'h03);
    frame_body(1, 8'h03, 1'b0, 8'h00, 1'b0);
    start_frame(2, 8'hFF);
    frame_body(2, 8'hFF, 1'b0, 8'h00, 1'b0);
    start_frame(2, 8'h01);
    frame_body(2, 8'h01, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_options();
    start_frame(3, 8'hFF);
    frame_body(3, 8'hFF, 1'b0, 8'h00, 1'b0);
    start_frame(3, 8'h35);
    frame_body(3, 8'h35, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_handshake();
    start_frame(0, 8'h55);
    frame_body(0, 8'h55, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_back_to_back();
    start_frame(0, 8'h55);
    frame_body(0, 8'h55, 1'b1, 8'h3C, 1'b0);
    frame_body(0, 8'h3C, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_abort();
    start_frame(0, 8'h55);
    // Data bit 3 occupies cycles N+17..N+20; reset lands at the N+18 edge.
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      if (i == 1) st[0] = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (tx_w[0] !== 1'b1 || rdy_w[0] !== 1'b1 || done_w[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_state: tx=%b rdy=%b done=%b, required 1 1 0",
               tx_w[0], rdy_w[0], done_w[0]);
    end
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_vec++;
      if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL abort_no_done cyc %0d: done=%b tx=%b, required 0 1",
                 i, done_w[0], tx_w[0]);
      end
    end
    start_frame(0, 8'h55);
    frame_body(0, 8'h55, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) dt[k] = 8'h00;
    test_reset();
    test_basic();
    test_parity();
    test_options();
    test_handshake();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
